// File: rtl/ifu_prefetch_pkg.sv
// rtl/ifu_prefetch_pkg.sv - shared constants for the instruction-fetch unit
package ifu_prefetch_pkg;

    localparam logic [63:0] PC_START  = 64'h8000_0000;
    localparam int          INST_BITS = 32;
    localparam int          INST_STEP = 4;

endpackage

// File: rtl/ifu_prefetch_if.sv
// rtl/ifu_prefetch_if.sv - fetch request, response, delivery and redirect signals
interface ifu_prefetch_if #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
);
    logic              o_req_valid;
    logic [ADDR_W-1:0] o_req_addr;
    logic              i_req_ready;
    logic              i_rsp_valid;
    logic [INST_W-1:0] i_rsp_data;
    logic              o_instr_valid;
    logic [INST_W-1:0] o_instr;
    logic [ADDR_W-1:0] o_instr_pc;
    logic              i_instr_ready;
    logic              i_branch_jump;
    logic [ADDR_W-1:0] i_next_pc;
    logic              i_hold;

    modport master (
        output o_req_valid, o_req_addr, o_instr_valid, o_instr, o_instr_pc,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_instr_ready,
               i_branch_jump, i_next_pc, i_hold
    );

    modport slave (
        input  o_req_valid, o_req_addr, o_instr_valid, o_instr, o_instr_pc,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_instr_ready,
               i_branch_jump, i_next_pc, i_hold
    );
endinterface

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - synchronous FIFO with flush, count, empty and full
module ifu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PW+1)'(DEPTH));
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop & ~flush & ~empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - credit-limited sequential fetcher with redirect flush
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PC_START,
    parameter int          ADDR_W   = 64,
    parameter int          INST_W   = INST_BITS,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ifu_prefetch_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + INST_W;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [ADDR_W-1:0] target;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     inflight_nxt;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_used;
    logic              fire;
    logic              rsp;
    logic              stale;
    logic              push;
    logic              pop;
    logic              redirect;
    logic              fifo_empty;
    logic              fifo_full;
    logic [EW-1:0]     head;

    assign redirect    = bus.i_branch_jump;
    assign target      = bus.i_next_pc & ~ADDR_W'(3);
    assign rsp         = bus.i_rsp_valid;
    assign stale       = (drop_cnt != '0);
    // Queued entries and outstanding requests share one credit pool, so a push can never overflow.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};

    assign bus.o_req_valid = rst_n & ~bus.i_hold & ~fifo_full & (credit_used < CREDITS);
    assign bus.o_req_addr  = req_pc;
    assign fire            = bus.o_req_valid & bus.i_req_ready;

    assign push = rsp & ~stale & ~redirect;
    assign pop  = ~fifo_empty & bus.i_instr_ready & ~redirect;

    assign inflight_nxt = inflight + CW'(fire) - CW'(rsp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc   <= RESET_PC[ADDR_W-1:0];
            rsp_pc   <= RESET_PC[ADDR_W-1:0];
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (redirect) begin
                // Everything fired up to and including this edge is stale; this cycle's response is already gone.
                req_pc   <= target;
                rsp_pc   <= target;
                drop_cnt <= inflight_nxt;
            end else begin
                if (fire) begin
                    req_pc <= req_pc + ADDR_W'(INST_STEP);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + ADDR_W'(INST_STEP);
                end
                if (rsp && stale) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    ifu_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({rsp_pc, bus.i_rsp_data}),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.o_instr_valid = ~fifo_empty;
    assign bus.o_instr_pc    = head[EW-1:INST_W];
    assign bus.o_instr       = head[INST_W-1:0];
endmodule
